// File: rtl/ex_muldiv_unit_pkg.sv
// Shared MD op encodings and default latencies for the execute-stage multiply/divide unit.
// MDU_MADD_EN adds the multiply-accumulate ops; they need a 4-bit op field.
package ex_muldiv_unit_pkg;

`ifdef MDU_MADD_EN
    localparam int MD_OP_W = 4;
`else
    localparam int MD_OP_W = 3;
`endif

    typedef logic [MD_OP_W-1:0] md_op_t;

    localparam md_op_t MD_MULT  = md_op_t'(0);
    localparam md_op_t MD_MULTU = md_op_t'(1);
    localparam md_op_t MD_DIV   = md_op_t'(2);
    localparam md_op_t MD_DIVU  = md_op_t'(3);
    localparam md_op_t MD_MTHI  = md_op_t'(4);
    localparam md_op_t MD_MTLO  = md_op_t'(5);
`ifdef MDU_MADD_EN
    localparam md_op_t MD_MADD  = md_op_t'(8);
    localparam md_op_t MD_MADDU = md_op_t'(9);
    localparam md_op_t MD_MSUB  = md_op_t'(10);
    localparam md_op_t MD_MSUBU = md_op_t'(11);
`endif

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that occupy the unit for a multi-cycle run.
    function automatic logic md_is_long(input md_op_t op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_compute.sv
// Combinational MD datapath: 64-bit {HI,LO} result for op/rs/rt, plus divide-by-zero flag.
// Zero latency; no handshake. MDU_MADD_EN adds the {HI,LO} accumulator adder.
module ex_muldiv_unit_compute
    import ex_muldiv_unit_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] den;
    logic               sdiv_ovf;
    logic        [31:0] quo_s, rem_s, quo_u, rem_u;

    assign prod_s   = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u   = {32'd0, rs} * {32'd0, rt};
    assign div0     = md_is_div(op) && (rt == 32'd0);
    // Substitute divisor 1 on div0 so the divider never sees zero; the result is discarded.
    assign den      = (rt == 32'd0) ? 32'd1 : rt;
    assign sdiv_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    assign quo_s = sdiv_ovf ? 32'h8000_0000 : 32'($signed(rs) / $signed(den));
    assign rem_s = sdiv_ovf ? 32'd0         : 32'($signed(rs) % $signed(den));
    assign quo_u = rs / den;
    assign rem_u = rs % den;

    always_comb begin
        result = {hi, lo};
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quo_s};
            MD_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
            MD_MSUB:  result = {hi, lo} - prod_s;
            MD_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; MTHI/MTLO write in one edge.
// MULT/DIV: busy for MULT_CYCLES/DIV_CYCLES then commit; start while busy is ignored.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (MULT_CYCLES latency).
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_t      op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [3:0]  counter;
    logic [63:0] pending;
    logic        pending_skip;
    logic [63:0] result;
    logic        div0;

    ex_muldiv_unit_compute u_compute (
        .op     (op),
        .rs     (rs_data),
        .rt     (rt_data),
        .hi     (hi_out),
        .lo     (lo_out),
        .result (result),
        .div0   (div0)
    );

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= 4'd0;
            pending      <= 64'd0;
            pending_skip <= 1'b0;
            hi_out       <= 32'd0;
            lo_out       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == MD_MTHI) begin
                            hi_out <= rs_data;
                        end else if (op == MD_MTLO) begin
                            lo_out <= rs_data;
                        end else if (md_is_long(op)) begin
                            pending      <= result;
                            pending_skip <= div0;
                            counter      <= md_is_div(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state        <= RUN;
                        end
                    end
                end
                RUN: begin
                    counter <= counter - 4'd1;
                    // Commit on the last busy cycle so busy and new HI/LO change together.
                    if (counter == 4'd1) begin
                        state <= IDLE;
                        if (!pending_skip) begin
                            hi_out <= pending[63:32];
                            lo_out <= pending[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int N_MUL = 5;
    localparam int N_DIV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    md_op_t      op;
    logic [31:0] rs_data, rt_data;
    logic        busy;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] mhi, mlo;

    ex_muldiv_unit #(.MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one MD instruction, from the ISA rules.
    task automatic model(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
        longint sa, sb, sp, q, r;
        longint unsigned ua, ub, up;
        logic [63:0] acc;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        nhi = hi; nlo = lo; lat = 0;
        case (o)
            MD_MULT:  begin sp = sa * sb; nhi = sp[63:32]; nlo = sp[31:0]; lat = N_MUL; end
            MD_MULTU: begin up = ua * ub; nhi = up[63:32]; nlo = up[31:0]; lat = N_MUL; end
            MD_DIV: begin
                lat = N_DIV;
                if (b != 0) begin q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0]; end
            end
            MD_DIVU: begin
                lat = N_DIV;
                if (b != 0) begin up = ua / ub; nlo = up[31:0]; up = ua % ub; nhi = up[31:0]; end
            end
            MD_MTHI: nhi = a;
            MD_MTLO: nlo = a;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                lat = N_MUL;
                acc = {hi, lo};
                sp  = sa * sb;
                up  = ua * ub;
                if (o == MD_MADD)       acc = acc + sp;
                else if (o == MD_MADDU) acc = acc + up;
                else if (o == MD_MSUB)  acc = acc - sp;
                else                    acc = acc - up;
                nhi = acc[63:32]; nlo = acc[31:0];
            end
`endif
            default: ;
        endcase
    endtask

    // inj_kind 1: stray DIV start at busy cycle inj_cyc; 2: reset at busy cycle inj_cyc.
    task automatic run_op(input string tag, input md_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input int inj_cyc, input int inj_kind);
        logic [31:0] nhi, nlo;
        int lat, nb;
        logic steady, seen_busy;
        model(o, a, b, mhi, mlo, nhi, nlo, lat);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0;
        nb = 0; steady = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (!busy) break;
            nb++;
            if (hi_out !== mhi || lo_out !== mlo) steady = 1'b0;
            if (i == inj_cyc && inj_kind == 1) begin
                start = 1'b1; op = MD_DIV; rs_data = $urandom; rt_data = 32'd3;
            end
            if (i == inj_cyc && inj_kind == 2) reset = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (reset) begin
                reset = 1'b0;
                break;
            end
        end
        chk({tag, "_steady"}, 64'(steady), 64'd1);
        if (inj_kind == 2) begin
            chk({tag, "_busycyc"}, 64'(nb), 64'(inj_cyc));
            mhi = 32'd0; mlo = 32'd0;
            seen_busy = 1'b0;
            repeat (12) begin
                if (busy || hi_out !== 32'd0 || lo_out !== 32'd0) seen_busy = 1'b1;
                @(negedge clk);
            end
            chk({tag, "_nolate"}, 64'(seen_busy), 64'd0);
            chk({tag, "_hilo"}, {hi_out, lo_out}, 64'd0);
        end else begin
            chk({tag, "_lat"}, 64'(nb), 64'(lat));
            chk({tag, "_hilo"}, {hi_out, lo_out}, {nhi, nlo});
            mhi = nhi; mlo = nlo;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = MD_MULT; rs_data = '0; rt_data = '0;
        mhi = 32'd0; mlo = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
        chk("mult_neg_exact", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 0, 0);
        chk("divu_exact", {hi_out, lo_out}, {32'd2, 32'd14});
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_neg_exact", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("div_ovf_exact", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

        run_op("mthi_pre", MD_MTHI, 32'h11, 32'd0, 0, 0);
        run_op("mtlo_pre", MD_MTLO, 32'h22, 32'd0, 0, 0);
        run_op("div0", MD_DIV, 32'h1234, 32'd0, 0, 0);
        chk("div0_exact", {hi_out, lo_out}, {32'h11, 32'h22});

        // Back-to-back MTHI then MTLO: each visible one cycle after its start.
        @(negedge clk);
        start = 1'b1; op = MD_MTHI; rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mt_b2b_hi", {hi_out, lo_out}, {32'hDEAD_BEEF, 32'h22});
        chk("mt_b2b_busy1", 64'(busy), 64'd0);
        op = MD_MTLO; rs_data = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        chk("mt_b2b_lo", {hi_out, lo_out}, {32'hDEAD_BEEF, 32'h1234_5678});
        chk("mt_b2b_busy2", 64'(busy), 64'd0);
        mhi = 32'hDEAD_BEEF; mlo = 32'h1234_5678;

        run_op("unused6", md_op_t'(6), 32'hAAAA_5555, 32'd9, 0, 0);
        run_op("unused7", md_op_t'(7), 32'h5555_AAAA, 32'd1, 0, 0);

        run_op("multu_stray", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1);
        chk("multu_stray_exact", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        run_op("multu_reset", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 2);

`ifdef MDU_MADD_EN
        run_op("madd_lo", MD_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 0);
        run_op("maddu", MD_MADDU, 32'd1, 32'd1, 0, 0);
        chk("maddu_exact", {hi_out, lo_out}, {32'd1, 32'd0});
        run_op("msub", MD_MSUB, 32'd1, 32'd2, 0, 0);
        chk("msub_exact", {hi_out, lo_out}, {32'd0, 32'hFFFF_FFFE});
`endif

        for (int n = 0; n < 40; n++) begin
            md_op_t ro;
`ifdef MDU_MADD_EN
            ro = md_op_t'($urandom_range(0, 11));
`else
            ro = md_op_t'($urandom_range(0, 7));
`endif
            run_op("rand", ro, pick(), pick(), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
